// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
//   Groups the display-data side and the pin side of seg7_scan_driver.
//   master : score/game logic (drives digit data, observes frame/pins)
//   slave  : seg7_scan_driver
//
//   digits_i     4*NUM_DIGITS  hex nibble per digit, digit 0 in bits [3:0]
//   digit_en_i   NUM_DIGITS    per-digit enable
//   lz_blank_i   1             leading-zero suppression enable
//   brightness_i 4             duty setting (only with SEG7_BRIGHTNESS_EN)
//   frame_o      1             pulse on the snapshot cycle
//   anode_o      NUM_DIGITS    active-low digit selects
//   segments_o   7             active-low segments, bit0=A .. bit6=G
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   digit_en_i;
    logic                    lz_blank_i;
    logic                    frame_o;
    logic [NUM_DIGITS-1:0]   anode_o;
    logic [6:0]              segments_o;

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]              brightness_i;

    modport master (
        output digits_i, digit_en_i, lz_blank_i, brightness_i,
        input  frame_o, anode_o, segments_o
    );
    modport slave (
        input  digits_i, digit_en_i, lz_blank_i, brightness_i,
        output frame_o, anode_o, segments_o
    );
`else
    modport master (
        output digits_i, digit_en_i, lz_blank_i,
        input  frame_o, anode_o, segments_o
    );
    modport slave (
        input  digits_i, digit_en_i, lz_blank_i,
        output frame_o, anode_o, segments_o
    );
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//   Each digit owns a slot of SLOT_TICKS clocks; the first BLANK_TICKS of a
//   slot are dark (anti-ghosting dead time). Digit data is snapshotted once
//   per frame on the last cycle of the last slot so the display never tears.
//
//   Parameters:
//     NUM_DIGITS  2..8
//     SLOT_TICKS  >= 4
//     BLANK_TICKS 1 .. SLOT_TICKS-1
//
//   Ports:
//     clk_i  system clock
//     rst_i  synchronous, active-high reset
//     bus    seg7_scan_driver_if.slave (digit data in, anode/segment pins out)
//
//   Optional feature macro: SEG7_BRIGHTNESS_EN
//     Adds bus.brightness_i; the lit part of DRIVE shrinks to the first
//     (b+1)/16 of the DRIVE phase, b being the snapshotted brightness.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_TICKS  = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = $clog2(SLOT_TICKS);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         CNT_LAST  = CW'(SLOT_TICKS - 1);
    localparam logic [CW-1:0]         CNT_PRE   = CW'(SLOT_TICKS - 2);
    localparam logic [CW-1:0]         CNT_BLANK = CW'(BLANK_TICKS);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);

    // Scan position
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;

    // Per-frame shadow copies of the inputs
    logic [4*NUM_DIGITS-1:0] r_sh_dig;
    logic [NUM_DIGITS-1:0]   r_sh_en;
    logic                    r_sh_lz;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]              r_sh_bri;
`endif

    // Registered outputs
    logic                    r_frame;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_seg;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_in_win;
    logic                    w_lit;
    logic                    w_all0;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [3:0]              w_cur_dig;

    // Active-low hex glyphs, bit0=A .. bit6=G
    function automatic logic [6:0] f_hex2seg(input logic [3:0] v);
        case (v)
            4'h0: f_hex2seg = 7'b1000000;
            4'h1: f_hex2seg = 7'b1111001;
            4'h2: f_hex2seg = 7'b0100100;
            4'h3: f_hex2seg = 7'b0110000;
            4'h4: f_hex2seg = 7'b0011001;
            4'h5: f_hex2seg = 7'b0010010;
            4'h6: f_hex2seg = 7'b0000010;
            4'h7: f_hex2seg = 7'b1111000;
            4'h8: f_hex2seg = 7'b0000000;
            4'h9: f_hex2seg = 7'b0010000;
            4'hA: f_hex2seg = 7'b0001000;
            4'hB: f_hex2seg = 7'b0000011;
            4'hC: f_hex2seg = 7'b1000110;
            4'hD: f_hex2seg = 7'b0100001;
            4'hE: f_hex2seg = 7'b0000110;
            default: f_hex2seg = 7'b0001110;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_cur_dig   = r_sh_dig[4*r_idx +: 4];

    // Leading-zero suppression: walk down from the most significant digit,
    // a digit is blank while every digit at or above it is zero. Digit 0
    // always stays visible.
    always_comb begin
        w_supp = '0;
        w_all0 = r_sh_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_all0    = w_all0 && (r_sh_dig[4*i +: 4] == 4'h0);
            w_supp[i] = w_all0;
        end
    end

`ifdef SEG7_BRIGHTNESS_EN
    localparam int unsigned DRIVE_W = SLOT_TICKS - BLANK_TICKS;
    logic [31:0] w_c;

    // c*16 < W*(b+1); w_c underflows during BLANK but is masked there
    assign w_c      = 32'(r_cnt) - 32'(BLANK_TICKS);
    assign w_in_win = (r_cnt >= CNT_BLANK) &&
                      ((w_c << 4) < (32'(DRIVE_W) * (32'(r_sh_bri) + 32'd1)));
`else
    assign w_in_win = (r_cnt >= CNT_BLANK);
`endif

    assign w_lit = w_in_win && r_sh_en[r_idx] && !w_supp[r_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_sh_dig <= '0;
            r_sh_en  <= '0;
            r_sh_lz  <= 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
            r_sh_bri <= 4'hF;
`endif
            r_frame  <= 1'b0;
            r_anode  <= '1;
            r_seg    <= 7'h7F;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

            if (w_frame_end) begin
                r_sh_dig <= bus.digits_i;
                r_sh_en  <= bus.digit_en_i;
                r_sh_lz  <= bus.lz_blank_i;
`ifdef SEG7_BRIGHTNESS_EN
                r_sh_bri <= bus.brightness_i;
`endif
            end

            // Registered one cycle early so frame_o is high exactly on the
            // snapshot cycle; a reset in between simply clears it.
            r_frame <= (r_cnt == CNT_PRE) && (r_idx == IDX_LAST);

            r_anode <= w_lit ? ~(ONE_HOT0 << r_idx) : '1;
            r_seg   <= w_lit ? f_hex2seg(w_cur_dig) : 7'h7F;
        end
    end

    assign bus.frame_o    = r_frame;
    assign bus.anode_o    = r_anode;
    assign bus.segments_o = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SLOT_TICKS=8,
// BLANK_TICKS=2 (32-cycle frames). Each frame task starts on the cycle whose
// scan state is slot 0 / cnt 0 and ends on the same point of the next frame.
module tb_seg7_scan_driver;
    localparam int ND     = 4;
    localparam int FULL_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .SLOT_TICKS (8),
        .BLANK_TICKS(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand table of active-low glyphs
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
            4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
            4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
            4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
            4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0010000;
            4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
            4'hC: seg_of = 7'b1000110;  4'hD: seg_of = 7'b0100001;
            4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b0001110;
        endcase
    endfunction

    // Expected pins one cycle after scan position p (0..31) of a frame.
    // vis: hand-computed set of slots that light up; wid: lit cycles per slot.
    function automatic void exp_out(input int p, input logic [3:0] vis,
                                    input logic [15:0] dig, input int wid,
                                    output logic [3:0] an, output logic [6:0] sg);
        int  slot;
        int  c;
        logic lit;
        slot = p / 8;
        c    = p % 8;
        lit  = (c >= 2) && (c - 2 < wid) && vis[slot];
        an   = lit ? ~(4'b0001 << slot) : 4'hF;
        sg   = lit ? seg_of(dig[slot*4 +: 4]) : 7'h7F;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.anode_o !== 4'hF || bus.segments_o !== 7'h7F || bus.frame_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset got an=%b seg=%b fr=%b want an=1111 seg=1111111 fr=0",
                     bus.anode_o, bus.segments_o, bus.frame_o);
        end
        rst = 1'b0;
    endtask

    // Called at cycle 0 after reset release; ends at cycle 32.
    task automatic test_power_up_dark();
        for (int cyc = 0; cyc <= 32; cyc++) begin
            if (cyc > 0) tick();
            n_checks++;
            if (bus.anode_o !== 4'hF || bus.segments_o !== 7'h7F || bus.frame_o !== (cyc == 31)) begin
                n_errors++;
                $display("FAIL power_up_dark cyc=%0d got an=%b seg=%b fr=%b want an=1111 seg=1111111 fr=%b",
                         cyc, bus.anode_o, bus.segments_o, bus.frame_o, cyc == 31);
            end
        end
    endtask

    task automatic test_snapshot_hold();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p < 32; p++) begin
            tick();
            if (p == 12) bus.digits_i = 16'h8888;
            exp_out(p, 4'hF, 16'h1234, FULL_W, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== (p == 30)) begin
                n_errors++;
                $display("FAIL snapshot_hold p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es, p == 30);
            end
        end
    endtask

    task automatic test_new_snapshot();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p < 32; p++) begin
            tick();
            if (p == 20) begin
                bus.digits_i   = 16'h0050;
                bus.lz_blank_i = 1'b1;
            end
            exp_out(p, 4'hF, 16'h8888, FULL_W, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== (p == 30)) begin
                n_errors++;
                $display("FAIL new_snapshot p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es, p == 30);
            end
        end
    endtask

    // 0050 with suppression: slots 2,3 blank, slot 1 shows 5, slot 0 shows 0
    task automatic test_lz_blank();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p < 32; p++) begin
            tick();
            if (p == 20) begin
                bus.digits_i   = 16'hABCF;
                bus.lz_blank_i = 1'b0;
                bus.digit_en_i = 4'b0101;
            end
            exp_out(p, 4'b0011, 16'h0050, FULL_W, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== (p == 30)) begin
                n_errors++;
                $display("FAIL lz_blank p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es, p == 30);
            end
        end
    endtask

    // Enables 0101: slot 0 shows F, slot 2 shows b, slots 1 and 3 dark
    task automatic test_digit_en();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p < 32; p++) begin
            tick();
            if (p == 20) begin
                bus.digits_i   = 16'h0000;
                bus.lz_blank_i = 1'b1;
                bus.digit_en_i = 4'hF;
            end
            exp_out(p, 4'b0101, 16'hABCF, FULL_W, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== (p == 30)) begin
                n_errors++;
                $display("FAIL digit_en p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es, p == 30);
            end
        end
    endtask

    // All zeros with suppression: only digit 0 stays lit, showing 0
    task automatic test_lz_all_zero();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p < 32; p++) begin
            tick();
            if (p == 20) begin
                bus.digits_i   = 16'h1234;
                bus.lz_blank_i = 1'b0;
            end
            exp_out(p, 4'b0001, 16'h0000, FULL_W, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== (p == 30)) begin
                n_errors++;
                $display("FAIL lz_all_zero p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es, p == 30);
            end
        end
    endtask

    // Runs 1234 until scan state slot 2 / cnt 5, then pulses reset once.
    task automatic test_reset_midslot();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p <= 20; p++) begin
            tick();
            exp_out(p, 4'hF, 16'h1234, FULL_W, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_midslot_pre p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=0",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.anode_o !== 4'hF || bus.segments_o !== 7'h7F || bus.frame_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_midslot got an=%b seg=%b fr=%b want an=1111 seg=1111111 fr=0",
                     bus.anode_o, bus.segments_o, bus.frame_o);
        end
    endtask

    task automatic test_after_reset();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p < 32; p++) begin
            tick();
`ifdef SEG7_BRIGHTNESS_EN
            if (p == 20) bus.brightness_i = 4'd7;
`endif
            exp_out(p, 4'hF, 16'h1234, FULL_W, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== (p == 30)) begin
                n_errors++;
                $display("FAIL after_reset p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es, p == 30);
            end
        end
    endtask

`ifdef SEG7_BRIGHTNESS_EN
    // b=7 over W=6: lit while c*16 < 48, i.e. c = 0,1,2
    task automatic test_brightness();
        logic [3:0] ea;
        logic [6:0] es;
        for (int p = 0; p < 32; p++) begin
            tick();
            exp_out(p, 4'hF, 16'h1234, 3, ea, es);
            n_checks++;
            if (bus.anode_o !== ea || bus.segments_o !== es || bus.frame_o !== (p == 30)) begin
                n_errors++;
                $display("FAIL brightness p=%0d got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b",
                         p, bus.anode_o, bus.segments_o, bus.frame_o, ea, es, p == 30);
            end
        end
    endtask
`endif

    initial begin
        bus.digits_i   = 16'h0;
        bus.digit_en_i = 4'h0;
        bus.lz_blank_i = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
        bus.brightness_i = 4'hF;
`endif
        test_reset();
        bus.digits_i   = 16'h1234;
        bus.digit_en_i = 4'hF;
        bus.lz_blank_i = 1'b0;
        test_power_up_dark();
        test_snapshot_hold();
        test_new_snapshot();
        test_lz_blank();
        test_digit_en();
        test_lz_all_zero();
        test_reset_midslot();
        test_power_up_dark();
        test_after_reset();
`ifdef SEG7_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
